// File: rtl/aircon_pkg.sv
// -----------------------------------------------------------------------------
// aircon_pkg
// Shared definitions for the aircon runtime controller:
//   - state_t        : controller state encoding (OFF/IDLE/COOL/HOLD)
//   - TEMP_MIN       : lowest legal setpoint, lower stored values clamp up
//   - DEF_*          : default tuning values for the controller parameters
//   - clamp_setpoint : maps a stored setpoint onto the legal range
// -----------------------------------------------------------------------------
package aircon_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_IDLE = 2'd1,
        ST_COOL = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [4:0] TEMP_MIN = 5'b10001;

    localparam int DEF_HYST          = 1;
    localparam int DEF_MIN_OFF_TICKS = 3;
    localparam int DEF_TIMER_UNIT    = 60;
    localparam int DEF_PWM_BITS      = 3;

    function automatic logic [4:0] clamp_setpoint(input logic [4:0] t);
        return (t < TEMP_MIN) ? TEMP_MIN : t;
    endfunction

endpackage

// File: rtl/aircon_off_timer.sv
// -----------------------------------------------------------------------------
// aircon_off_timer
// Off-timer countdown: a sub-counter divides tick pulses by TIMER_UNIT and
// timer_left counts down whole units. Expiry produces a one-cycle pulse.
// Ports:
//   i_clk, i_rst_n   : clock, synchronous active-low reset
//   i_power          : power switch level (low clears the countdown)
//   i_run_en         : controller run enable (loads and counting need it)
//   i_tick           : time-base pulse
//   i_timer_load     : load pulse for i_timer_set
//   i_timer_set      : timer value in units, 0 = no countdown
//   o_timer_left     : remaining units
//   o_auto_off       : registered one-cycle expiry pulse
//   o_expire         : combinational expiry condition (clears run_en upstream)
// -----------------------------------------------------------------------------
module aircon_off_timer
    import aircon_pkg::*;
#(
    parameter int TIMER_UNIT = DEF_TIMER_UNIT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_power,
    input  logic       i_run_en,
    input  logic       i_tick,
    input  logic       i_timer_load,
    input  logic [4:0] i_timer_set,
    output logic [4:0] o_timer_left,
    output logic       o_auto_off,
    output logic       o_expire
);

    localparam int SUB_W = (TIMER_UNIT < 2) ? 1 : $clog2(TIMER_UNIT);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TIMER_UNIT - 1);

    logic [SUB_W-1:0] r_sub;
    logic [4:0]       r_left;
    logic             r_auto_off;

    logic w_load;
    logic w_count;
    logic w_wrap;
    logic w_expire;

    assign w_load   = i_timer_load & i_run_en;
    assign w_count  = i_tick & i_run_en & (r_left != 5'd0);
    assign w_wrap   = w_count & (r_sub == SUB_LAST);
    // A load in the same cycle as the final tick wins, so no expiry then.
    assign w_expire = i_power & ~w_load & w_wrap & (r_left == 5'd1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sub      <= '0;
            r_left     <= 5'd0;
            r_auto_off <= 1'b0;
        end else begin
            r_auto_off <= w_expire;
            if (!i_power) begin
                r_sub  <= '0;
                r_left <= 5'd0;
            end else if (w_load) begin
                r_sub  <= '0;
                r_left <= i_timer_set;
            end else if (w_count) begin
                if (w_wrap) begin
                    r_sub  <= '0;
                    r_left <= r_left - 5'd1;
                end else begin
                    r_sub <= r_sub + 1'b1;
                end
            end
        end
    end

    assign o_timer_left = r_left;
    assign o_auto_off   = r_auto_off;
    assign o_expire     = w_expire;

endmodule

// File: rtl/aircon_runtime_ctrl.sv
// -----------------------------------------------------------------------------
// aircon_runtime_ctrl
// Drives the compressor (hysteresis + anti-short-cycle hold), fan PWM and the
// off-timer from the stored settings and the room temperature sensor.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   power       : power switch level; a rising edge enables running
//   tick        : one-cycle time-base pulse
//   set_temp    : stored setpoint (clamped up to TEMP_MIN)
//   room_temp   : sensor reading
//   fan_set     : stored fan speed, low PWM_BITS bits used
//   timer_set   : stored off-timer in units, timer_load loads it
//   compressor  : compressor drive (high in COOL)
//   fan_drive   : fan PWM output
//   timer_left  : remaining timer units
//   auto_off    : one-cycle pulse on timer expiry
//   state       : 0=OFF 1=IDLE 2=COOL 3=HOLD
// -----------------------------------------------------------------------------
module aircon_runtime_ctrl
    import aircon_pkg::*;
#(
    parameter int HYST          = DEF_HYST,
    parameter int MIN_OFF_TICKS = DEF_MIN_OFF_TICKS,
    parameter int TIMER_UNIT    = DEF_TIMER_UNIT,
    parameter int PWM_BITS      = DEF_PWM_BITS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       power,
    input  logic       tick,
    input  logic [4:0] set_temp,
    input  logic [4:0] room_temp,
    input  logic [4:0] fan_set,
    input  logic [4:0] timer_set,
    input  logic       timer_load,
    output logic       compressor,
    output logic       fan_drive,
    output logic [4:0] timer_left,
    output logic       auto_off,
    output logic [1:0] state
);

    localparam int HOLD_W = (MIN_OFF_TICKS < 1) ? 1 : $clog2(MIN_OFF_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_OFF_TICKS);

    logic                r_power_q;
    logic                r_run_en;
    state_t              r_state;
    logic [HOLD_W-1:0]   r_hold;
    logic [PWM_BITS-1:0] r_pwm;
    logic                r_comp;
    logic                r_fan;

    state_t      w_next;
    logic [5:0]  w_sp6;
    logic [5:0]  w_room6;
    logic        w_demand;
    logic        w_satisfied;
    logic        w_expire;
    logic        w_unused_fan;

    // Widen to 6 bits so sp + HYST cannot wrap.
    assign w_sp6       = {1'b0, clamp_setpoint(set_temp)};
    assign w_room6     = {1'b0, room_temp};
    assign w_demand    = (w_room6 >= (w_sp6 + 6'(HYST)));
    assign w_satisfied = (w_room6 <= w_sp6);
    assign w_unused_fan = &fan_set[4:PWM_BITS];

    aircon_off_timer #(
        .TIMER_UNIT (TIMER_UNIT)
    ) u_off_timer (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_power      (power),
        .i_run_en     (r_run_en),
        .i_tick       (tick),
        .i_timer_load (timer_load),
        .i_timer_set  (timer_set),
        .o_timer_left (timer_left),
        .o_auto_off   (auto_off),
        .o_expire     (w_expire)
    );

    always_comb begin
        w_next = r_state;
        if (!r_run_en) begin
            w_next = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF:  w_next = ST_HOLD;
                ST_IDLE: if (w_demand) w_next = ST_COOL;
                ST_COOL: if (w_satisfied) w_next = ST_HOLD;
                ST_HOLD: if (r_hold == '0) w_next = ST_IDLE;
                default: w_next = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_power_q <= 1'b0;
            r_run_en  <= 1'b0;
            r_state   <= ST_OFF;
            r_hold    <= '0;
            r_pwm     <= '0;
            r_comp    <= 1'b0;
            r_fan     <= 1'b0;
        end else begin
            r_power_q <= power;
            // Power low dominates; expiry needs a fresh power edge to restart.
            if (!power || w_expire) begin
                r_run_en <= 1'b0;
            end else if (!r_power_q) begin
                r_run_en <= 1'b1;
            end

            r_state <= w_next;

            // Entry into HOLD reloads the hold time; a tick that same cycle is dropped.
            if (w_next == ST_OFF) begin
                r_hold <= '0;
            end else if (w_next == ST_HOLD && r_state != ST_HOLD) begin
                r_hold <= HOLD_LOAD;
            end else if (r_state == ST_HOLD && tick && r_hold != '0) begin
                r_hold <= r_hold - 1'b1;
            end

            if (r_state == ST_OFF) begin
                r_pwm <= '0;
            end else begin
                r_pwm <= r_pwm + 1'b1;
            end

            r_comp <= (w_next == ST_COOL);
            r_fan  <= (w_next != ST_OFF) && (r_pwm < fan_set[PWM_BITS-1:0]);
        end
    end

    assign compressor = r_comp;
    assign fan_drive  = r_fan;
    assign state      = r_state;

endmodule

// File: tb/tb_aircon_runtime_ctrl.sv
// Bench for aircon_runtime_ctrl (TIMER_UNIT reduced to 2 to keep countdowns short).
module tb_aircon_runtime_ctrl;
    import aircon_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       power = 1'b0;
    logic       tick = 1'b0;
    logic [4:0] set_temp = 5'd24;
    logic [4:0] room_temp = 5'd24;
    logic [4:0] fan_set = 5'd0;
    logic [4:0] timer_set = 5'd0;
    logic       timer_load = 1'b0;
    logic       compressor;
    logic       fan_drive;
    logic [4:0] timer_left;
    logic       auto_off;
    logic [1:0] state;

    aircon_runtime_ctrl #(
        .HYST          (1),
        .MIN_OFF_TICKS (3),
        .TIMER_UNIT    (2),
        .PWM_BITS      (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .power      (power),
        .tick       (tick),
        .set_temp   (set_temp),
        .room_temp  (room_temp),
        .fan_set    (fan_set),
        .timer_set  (timer_set),
        .timer_load (timer_load),
        .compressor (compressor),
        .fan_drive  (fan_drive),
        .timer_left (timer_left),
        .auto_off   (auto_off),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       power;
        logic       tick;
        logic [4:0] st;
        logic [4:0] rm;
        logic [4:0] fs;
        logic [4:0] ts;
        logic       ld;
        logic [1:0] e_state;
        logic       e_comp;
        logic [4:0] e_left;
        logic       e_auto;
        logic       chk_st;   // state/compressor checked (skipped on hold-expiry edge)
        logic       chk_fan;  // fan_drive expected 0
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   vidx  = 0;

    function automatic vec_t mk(input logic r, input logic p, input logic t,
                                input logic [4:0] st, input logic [4:0] rm,
                                input logic [4:0] fs, input logic [4:0] ts,
                                input logic ld, input logic [1:0] es,
                                input logic ec, input logic [4:0] el,
                                input logic ea, input logic cs, input logic cf);
        vec_t v;
        v.rst_n = r; v.power = p; v.tick = t; v.st = st; v.rm = rm; v.fs = fs;
        v.ts = ts; v.ld = ld; v.e_state = es; v.e_comp = ec; v.e_left = el;
        v.e_auto = ea; v.chk_st = cs; v.chk_fan = cf;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst_n = v.rst_n; power = v.power; tick = v.tick; set_temp = v.st;
        room_temp = v.rm; fan_set = v.fs; timer_set = v.ts; timer_load = v.ld;
        sb.push_back(v);
    endtask

    // Scoreboard: each pushed record describes the outputs after the next edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            vec_t e;
            e = sb.pop_front();
            n_vec++;
            if (e.chk_st && state !== e.e_state) begin
                n_err++;
                $display("FAIL state v%0d: got %0d expected %0d", vidx, state, e.e_state);
            end
            if (e.chk_st && compressor !== e.e_comp) begin
                n_err++;
                $display("FAIL compressor v%0d: got %0b expected %0b", vidx, compressor, e.e_comp);
            end
            if (timer_left !== e.e_left) begin
                n_err++;
                $display("FAIL timer_left v%0d: got %0d expected %0d", vidx, timer_left, e.e_left);
            end
            if (auto_off !== e.e_auto) begin
                n_err++;
                $display("FAIL auto_off v%0d: got %0b expected %0b", vidx, auto_off, e.e_auto);
            end
            if (e.chk_fan && fan_drive !== 1'b0) begin
                n_err++;
                $display("FAIL fan_drive v%0d: got %0b expected 0", vidx, fan_drive);
            end
            vidx++;
        end
    end

    task automatic fan_window(input logic [4:0] fs, input int exp_hi);
        int hi;
        hi = 0;
        @(negedge clk);
        fan_set = fs;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (fan_drive) hi++;
            @(negedge clk);
        end
        n_vec++;
        if (hi != exp_hi) begin
            n_err++;
            $display("FAIL fan_duty fs=%0d: got %0d/8 expected %0d/8", fs, hi, exp_hi);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset, power-up hold, hysteresis, clamped setpoint
        tbl.push_back(mk(0,0,0,24,24,0,0,0, ST_OFF, 0,0,0,1,1));
        tbl.push_back(mk(0,0,0,24,24,0,0,0, ST_OFF, 0,0,0,1,1));
        tbl.push_back(mk(1,0,0,24,24,0,0,0, ST_OFF, 0,0,0,1,1));
        tbl.push_back(mk(1,1,0,24,24,0,0,0, ST_OFF, 0,0,0,1,1));
        tbl.push_back(mk(1,1,0,24,24,0,0,0, ST_HOLD,0,0,0,1,1));
        tbl.push_back(mk(1,1,1,24,24,0,0,0, ST_HOLD,0,0,0,1,1));
        tbl.push_back(mk(1,1,0,24,24,0,0,0, ST_HOLD,0,0,0,1,1));
        tbl.push_back(mk(1,1,1,24,24,0,0,0, ST_HOLD,0,0,0,1,1));
        tbl.push_back(mk(1,1,0,24,24,0,0,0, ST_HOLD,0,0,0,1,1));
        tbl.push_back(mk(1,1,1,24,24,0,0,0, ST_HOLD,0,0,0,0,1));
        tbl.push_back(mk(1,1,0,24,24,0,0,0, ST_IDLE,0,0,0,1,1));
        tbl.push_back(mk(1,1,0,24,24,0,0,0, ST_IDLE,0,0,0,1,1));
        tbl.push_back(mk(1,1,0,24,25,0,0,0, ST_COOL,1,0,0,1,1));
        tbl.push_back(mk(1,1,0,24,25,0,0,0, ST_COOL,1,0,0,1,1));
        tbl.push_back(mk(1,1,0,24,24,0,0,0, ST_HOLD,0,0,0,1,1));
        tbl.push_back(mk(1,1,0,24,26,0,0,0, ST_HOLD,0,0,0,1,1));
        tbl.push_back(mk(1,1,1,24,26,0,0,0, ST_HOLD,0,0,0,1,1));
        tbl.push_back(mk(1,1,1,24,26,0,0,0, ST_HOLD,0,0,0,1,1));
        tbl.push_back(mk(1,1,1,24,26,0,0,0, ST_HOLD,0,0,0,0,1));
        tbl.push_back(mk(1,1,0,24,26,0,0,0, ST_IDLE,0,0,0,0,1));
        tbl.push_back(mk(1,1,0,24,26,0,0,0, ST_COOL,1,0,0,1,1));
        tbl.push_back(mk(1,1,0,10,17,0,0,0, ST_HOLD,0,0,0,1,1));
        tbl.push_back(mk(1,1,1,10,18,0,0,0, ST_HOLD,0,0,0,1,1));
        tbl.push_back(mk(1,1,1,10,18,0,0,0, ST_HOLD,0,0,0,1,1));
        tbl.push_back(mk(1,1,1,10,18,0,0,0, ST_HOLD,0,0,0,0,1));
        tbl.push_back(mk(1,1,0,10,18,0,0,0, ST_IDLE,0,0,0,0,1));
        tbl.push_back(mk(1,1,0,10,18,0,0,0, ST_COOL,1,0,0,1,1));
        tbl.push_back(mk(1,1,0,10,17,0,0,0, ST_HOLD,0,0,0,1,1));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // fan duty in HOLD (no ticks, so the state stays put)
        @(negedge clk);
        set_temp = 5'd24; room_temp = 5'd17;
        fan_window(5'd3, 3);
        fan_window(5'd0, 0);
        fan_window(5'd7, 7);

        // power drop: run_en clears first, OFF and fan 0 one edge later
        apply(mk(1,0,0,24,17,7,0,0, ST_HOLD,0,0,0,1,0));
        apply(mk(1,0,0,24,17,7,0,0, ST_OFF, 0,0,0,1,1));

        // timer expiry (2 units of 2 ticks each)
        apply(mk(1,1,0,24,17,0,0,0, ST_OFF, 0,0,0,1,1));
        apply(mk(1,1,0,24,17,0,0,0, ST_HOLD,0,0,0,1,1));
        apply(mk(1,1,0,24,17,0,2,1, ST_HOLD,0,2,0,1,1));
        apply(mk(1,1,1,24,17,0,0,0, ST_HOLD,0,2,0,1,1));
        apply(mk(1,1,0,24,17,0,0,0, ST_HOLD,0,2,0,1,1));
        apply(mk(1,1,1,24,17,0,0,0, ST_HOLD,0,1,0,1,1));
        apply(mk(1,1,0,24,17,0,0,0, ST_HOLD,0,1,0,1,1));
        apply(mk(1,1,1,24,17,0,0,0, ST_HOLD,0,1,0,0,1));
        apply(mk(1,1,0,24,17,0,0,0, ST_IDLE,0,1,0,1,1));
        apply(mk(1,1,1,24,17,0,0,0, ST_IDLE,0,0,1,1,1));
        apply(mk(1,1,0,24,17,0,0,0, ST_OFF, 0,0,0,1,1));
        apply(mk(1,1,1,24,17,0,0,0, ST_OFF, 0,0,0,1,1));
        apply(mk(1,1,0,24,17,0,0,0, ST_OFF, 0,0,0,1,1));
        apply(mk(1,1,1,24,17,0,0,0, ST_OFF, 0,0,0,1,1));
        // power toggle restarts
        apply(mk(1,0,0,24,17,0,0,0, ST_OFF, 0,0,0,1,1));
        apply(mk(1,1,0,24,17,0,0,0, ST_OFF, 0,0,0,1,1));
        apply(mk(1,1,0,24,17,0,0,0, ST_HOLD,0,0,0,1,1));
        // load coincident with the expiring tick: reload, no auto_off
        apply(mk(1,1,0,24,17,0,1,1, ST_HOLD,0,1,0,1,1));
        apply(mk(1,1,1,24,17,0,0,0, ST_HOLD,0,1,0,1,1));
        apply(mk(1,1,1,24,17,0,3,1, ST_HOLD,0,3,0,1,1));
        apply(mk(1,1,0,24,17,0,0,0, ST_HOLD,0,3,0,1,1));
        apply(mk(1,1,1,24,17,0,0,0, ST_HOLD,0,3,0,0,1));
        apply(mk(1,1,1,24,17,0,0,0, ST_IDLE,0,2,0,1,1));
        apply(mk(1,1,1,24,17,0,0,0, ST_IDLE,0,2,0,1,1));
        apply(mk(1,1,0,24,17,0,0,0, ST_IDLE,0,2,0,1,1));
        apply(mk(1,1,0,24,26,0,0,0, ST_COOL,1,2,0,1,1));
        // power drop mid-COOL
        apply(mk(1,0,0,24,26,0,0,0, ST_COOL,1,0,0,1,1));
        apply(mk(1,0,0,24,26,0,0,0, ST_OFF, 0,0,0,1,1));
        // load on the power-up edge (run_en not yet set) is ignored
        apply(mk(1,1,0,24,26,0,5,1, ST_OFF, 0,0,0,1,1));
        apply(mk(1,1,0,24,17,0,0,0, ST_HOLD,0,0,0,1,1));
        apply(mk(1,1,1,24,17,0,0,0, ST_HOLD,0,0,0,1,1));
        apply(mk(1,1,1,24,17,0,0,0, ST_HOLD,0,0,0,1,1));
        apply(mk(1,1,1,24,17,0,0,0, ST_HOLD,0,0,0,0,1));
        apply(mk(1,1,0,24,17,0,0,0, ST_IDLE,0,0,0,1,1));
        apply(mk(1,1,0,24,26,0,0,0, ST_COOL,1,0,0,1,1));
        // reset mid-COOL
        apply(mk(0,1,0,24,26,0,0,0, ST_OFF, 0,0,0,1,1));
        apply(mk(0,1,0,24,26,0,0,0, ST_OFF, 0,0,0,1,1));

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
